mem_access: RTL and testbench
=============================

# mem_access

Memory-access stage of the RV32 core, directly downstream of `execute`. It takes the ALU result, effective address, store data and load/store controls from `execute`, and runs a request/grant/response transaction on the data bus. For RV32I loads and stores it generates byte enables, write-data lane steering, load sign/zero extension and misalignment detection. It hands one registered result per instruction to write-back and stalls `execute` while a bus transaction is outstanding.

## Interface
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: instruction from `execute` is present.
- `in_ready` output 1: stage can accept; high only in IDLE. Upstream holds all inputs while `in_valid && !in_ready`.
- `alu_result` input 32: non-memory result.
- `mem_addr` input 32: effective address.
- `mem_wdata` input 32: store data, unshifted rs2.
- `mem_read`, `mem_write` input 1 each: load / store. Both high is illegal and treated as a store.
- `funct3` input 3: 000 B, 001 H, 010 W, 100 BU, 101 HU. Other codes are treated as W.
- `rd` input 5, `reg_write` input 1: destination register and write enable.
- `dbus_req` output 1: bus request.
- `dbus_we` output 1: write.
- `dbus_addr` output 32: `{mem_addr[31:2],2'b00}`.
- `dbus_wdata` output 32: lane-steered store data.
- `dbus_be` output 4: byte enables.
- `dbus_gnt` input 1: request accepted.
- `dbus_rvalid` input 1, `dbus_rdata` input 32: read response.
- `wb_valid` output 1: one-cycle pulse, result for write-back.
- `wb_rd` output 5, `wb_data` output 32, `wb_reg_write` output 1: write-back fields.
- `misalign` output 1: one-cycle pulse with `wb_valid` on a misaligned access.

## Operation
- FSM states: IDLE, REQ, RESP.
- An instruction is accepted on an edge where `in_valid && in_ready`. On acceptance, address, funct3, rd, reg_write, op type, be and steered wdata are latched.
- Non-memory op: stay in IDLE. At the next edge, `wb_valid=1`, `wb_data=alu_result`, `wb_reg_write=reg_write`.
- Misalignment:
  - H/HU access is misaligned when `addr[0]=1`.
  - W access is misaligned when `addr[1:0]!=0`.
  - A misaligned access makes no bus request and stays in IDLE.
  - Next edge: `wb_valid=1`, `misalign=1`, `wb_reg_write=0`, `wb_data=0`.
- Aligned load or store: go to REQ.
  - In REQ, `dbus_req=1`, and addr/we/be/wdata are held stable until `dbus_gnt` is sampled high.
  - Store with gnt: go to IDLE. Next edge: `wb_valid=1`, `wb_reg_write=0`.
  - Load with gnt: go to RESP.
  - In RESP, `dbus_req=0`. When `dbus_rvalid` is sampled high: go to IDLE, `wb_valid=1`, `wb_data` is the extracted load value, `wb_reg_write=reg_write`.
- Byte enables:
  - B: `4'b0001<<addr[1:0]`.
  - H: `addr[1]` selects 0011 or 1100.
  - W: 1111.
- Store lanes:
  - B: byte replicated on all four lanes.
  - H: halfword replicated on both halves.
  - W: unchanged.
- Load extraction: select the byte or halfword by `addr[1:0]`. B/H sign-extend to 32 bits; BU/HU zero-extend.
- `dbus_rvalid` outside RESP is ignored. `dbus_gnt` outside REQ is ignored.
- `rd`/`reg_write` pass through unchanged except in the cases above that force `wb_reg_write=0`.

## Timing
- Reset values: state IDLE, `in_ready=1`, and all other outputs 0 (`dbus_*`, `wb_*`, `misalign`). Reset asserted in REQ or RESP aborts the transaction immediately (`dbus_req` falls asynchronously).
- Latencies, with acceptance at edge N:
  - Non-memory or misaligned: `wb_valid` high in cycle N+1.
  - Store: `dbus_req` high from N to the grant edge G; `wb_valid` high after G.
  - Load: response edge R ≥ G+1; `wb_valid` high after R.
- `in_ready` is low in REQ and RESP, and high again in the cycle after the terminating edge. A new instruction can be accepted on the same edge `wb_valid` rises, giving back-to-back non-memory throughput of 1 per cycle.
- Each `wb_valid` is a single-cycle pulse. `wb_*` fields hold their last value when `wb_valid=0`.

## Test plan
- ALU pass-through: `alu_result=32'h9999_9999`, rd=5, reg_write=1, no mem → next cycle `wb_valid=1`, `wb_data=32'h9999_9999`, `wb_rd=5`. Repeat with three back-to-back ops → three consecutive `wb_valid` pulses.
- SW, SB, SH store steering:
  - SW `mem_addr=32'h1000_0100`, wdata `32'hDEAD_BEEF`, gnt after 2 wait cycles → `dbus_addr=32'h1000_0100`, `be=1111`, `dbus_req` held 3 cycles, `in_ready` low throughout, then `wb_valid` with `wb_reg_write=0`.
  - SB to `...0103`, wdata `32'h0000_00AB` → `be=1000`, `wdata=32'hABAB_ABAB`.
  - SH to `...0102` → `be=1100`.
- Load extension, rdata `32'h8070_F0FF`:
  - LB at offset 0 → `32'hFFFF_FFFF`.
  - LBU at offset 1 → `32'h0000_00F0`.
  - LH at offset 2 → `32'hFFFF_8070`.
  - LHU at offset 2 → `32'h0000_8070`.
  - LW → `32'h8070_F0FF`.
- Response timing: load with gnt immediately and rvalid 3 cycles later → `wb_valid` exactly once, in the cycle after rvalid. A stray `rvalid` while in IDLE produces no `wb_valid`.
- Misalignment: LW at `...0102` and LH at `...0101` → no `dbus_req`; next cycle `misalign=1`, `wb_valid=1`, `wb_reg_write=0`.
- Reset mid-load: assert `rst` in RESP → `dbus_req=0`, `wb_valid=0`, `in_ready=1` immediately. After release, a fresh ALU op completes in 1 cycle.

Source files
------------

// File: rtl/mem_access_if.sv
// Data-bus interface between the memory-access stage and the data memory.
// The stage drives the request side as master; the memory answers with
// grant and read-response as slave.
interface mem_access_if;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_be;
    logic        dbus_gnt;
    logic        dbus_rvalid;
    logic [31:0] dbus_rdata;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
        input  dbus_gnt, dbus_rvalid, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
        output dbus_gnt, dbus_rvalid, dbus_rdata
    );
endinterface

// File: rtl/mem_access.sv
// RV32 memory-access stage: turns execute-stage load/store controls into a
// request/grant/response bus transaction, steers store lanes, extracts and
// extends load data, flags misaligned accesses and emits one registered
// write-back result per instruction.
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_result,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic        reg_write,
    mem_access_if.master dbus,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_reg_write,
    output logic        misalign
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    state_t state, state_nxt;

    logic        accept;
    logic        is_mem;
    logic        mis_now;

    logic [31:0] addr_p0;
    logic [31:0] wdata_p0;
    logic [3:0]  be_p0;
    logic        we_p0;
    logic [2:0]  f3_p0;
    logic [4:0]  rd_p0;
    logic        rw_p0;

    // Access width from funct3; codes outside B/H/BU/HU behave as a word.
    function automatic logic [1:0] size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

    function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    return 4'b0001 << off;
            SZ_H:    return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate narrow store data so the enabled lanes always carry it.
    function automatic logic [31:0] steer(input logic [1:0] size, input logic [31:0] d);
        case (size)
            SZ_B:    return {4{d[7:0]}};
            SZ_H:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            default: return |off;
        endcase
    endfunction

    // Pick the addressed byte/halfword; funct3[2] selects zero extension.
    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (size_of(f3))
            SZ_B:    return f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
            SZ_H:    return f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
            default: return rdata;
        endcase
    endfunction

    // Decode of the incoming instruction
    always_comb begin
        accept  = in_valid && in_ready;
        is_mem  = mem_read || mem_write;
        mis_now = is_mem && misaligned(size_of(funct3), mem_addr[1:0]);
    end

    // State register; reset aborts any outstanding transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && is_mem && !mis_now) state_nxt = REQ;
            REQ:     if (dbus.dbus_gnt) state_nxt = we_p0 ? IDLE : RESP;
            RESP:    if (dbus.dbus_rvalid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bus and handshake outputs; bus fields are zero whenever no request is up
    always_comb begin
        in_ready        = (state == IDLE);
        dbus.dbus_req   = (state == REQ);
        dbus.dbus_we    = 1'b0;
        dbus.dbus_addr  = 32'b0;
        dbus.dbus_wdata = 32'b0;
        dbus.dbus_be    = 4'b0;
        if (state == REQ) begin
            dbus.dbus_we    = we_p0;
            dbus.dbus_addr  = {addr_p0[31:2], 2'b00};
            dbus.dbus_wdata = wdata_p0;
            dbus.dbus_be    = be_p0;
        end
    end

    // ---- p0: instruction fields captured at acceptance ----
    // Capture address, controls, byte enables and steered store data
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_p0  <= mem_addr;
            we_p0    <= mem_write;
            f3_p0    <= funct3;
            rd_p0    <= rd;
            rw_p0    <= reg_write;
            be_p0    <= be_gen(size_of(funct3), mem_addr[1:0]);
            wdata_p0 <= steer(size_of(funct3), mem_wdata);
        end
    end

    // ---- write-back register: one pulse per terminating edge ----
    // Produce the write-back result for ALU ops, misaligned accesses, stores and loads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid     <= 1'b0;
            misalign     <= 1'b0;
            wb_rd        <= 5'b0;
            wb_data      <= 32'b0;
            wb_reg_write <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            misalign <= 1'b0;
            case (state)
                IDLE: if (accept && (!is_mem || mis_now)) begin
                    wb_valid     <= 1'b1;
                    misalign     <= mis_now;
                    wb_rd        <= rd;
                    wb_data      <= mis_now ? 32'b0 : alu_result;
                    wb_reg_write <= mis_now ? 1'b0 : reg_write;
                end
                REQ: if (dbus.dbus_gnt && we_p0) begin
                    wb_valid     <= 1'b1;
                    wb_rd        <= rd_p0;
                    wb_data      <= 32'b0;
                    wb_reg_write <= 1'b0;
                end
                RESP: if (dbus.dbus_rvalid) begin
                    wb_valid     <= 1'b1;
                    wb_rd        <= rd_p0;
                    wb_data      <= load_extract(f3_p0, addr_p0[1:0], dbus.dbus_rdata);
                    wb_reg_write <= rw_p0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: the stimulus side pushes expected
// write-back results (with their cycle) and expected bus requests; monitors
// on the falling edge pop and compare whatever the DUT presents.
module tb_mem_access;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        reg_write;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_reg_write;
    logic        misalign;

    mem_access_if dbus();

    mem_access dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_result   (alu_result),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .funct3       (funct3),
        .rd           (rd),
        .reg_write    (reg_write),
        .dbus         (dbus),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_reg_write (wb_reg_write),
        .misalign     (misalign)
    );

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        rw;
        logic        mis;
        logic        dchk;
    } wb_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_exp_t;

    wb_exp_t  wb_q[$];
    bus_exp_t bus_q[$];
    wb_exp_t  me;
    bus_exp_t mb;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: in the cycle following edge k, cyc == k
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Write-back and bus monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (wb_valid) begin
                if (wb_q.size() == 0) begin
                    chk("wb_unexpected", 32'(wb_valid), 32'd0);
                end else begin
                    me = wb_q.pop_front();
                    chk("wb_cycle", 32'(cyc), 32'(me.cyc));
                    chk("wb_rd", 32'(wb_rd), 32'(me.rd));
                    chk("wb_reg_write", 32'(wb_reg_write), 32'(me.rw));
                    chk("wb_misalign", 32'(misalign), 32'(me.mis));
                    if (me.dchk) chk("wb_data", wb_data, me.data);
                end
            end else if (misalign) begin
                chk("misalign_without_wb", 32'(misalign), 32'd0);
            end
            if (dbus.dbus_req) begin
                if (bus_q.size() == 0) begin
                    chk("bus_unexpected_req", 32'(dbus.dbus_req), 32'd0);
                end else begin
                    mb = bus_q[0];
                    chk("bus_addr", dbus.dbus_addr, mb.addr);
                    chk("bus_we", 32'(dbus.dbus_we), 32'(mb.we));
                    chk("bus_be", 32'(dbus.dbus_be), 32'(mb.be));
                    if (mb.we) chk("bus_wdata", dbus.dbus_wdata, mb.wdata);
                    chk("ready_in_req", 32'(in_ready), 32'd0);
                    if (dbus.dbus_gnt) void'(bus_q.pop_front());
                end
            end
        end
    end

    // Present one instruction and wait (bounded) for its acceptance edge
    task automatic issue(input logic [31:0] alu, input logic [31:0] addr, input logic [31:0] wd,
                         input logic rdq, input logic wrq, input logic [2:0] f3,
                         input logic [4:0] r, input logic rw, output int n);
        int k;
        alu_result = alu;
        mem_addr   = addr;
        mem_wdata  = wd;
        mem_read   = rdq;
        mem_write  = wrq;
        funct3     = f3;
        rd         = r;
        reg_write  = rw;
        in_valid   = 1'b1;
        k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("issue_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        n = cyc;
        in_valid  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic alu_op(input logic [31:0] v, input logic [4:0] r, input logic rw);
        int n;
        wb_exp_t e;
        issue(v, 32'h0, 32'h0, 1'b0, 1'b0, 3'b010, r, rw, n);
        e.cyc = n; e.rd = r; e.data = v; e.rw = rw; e.mis = 1'b0; e.dchk = 1'b1;
        wb_q.push_back(e);
    endtask

    task automatic misaligned_op(input logic wr, input logic [31:0] addr, input logic [2:0] f3,
                                 input logic [4:0] r);
        int n;
        wb_exp_t e;
        issue(32'h7777_7777, addr, 32'h1234_5678, !wr, wr, f3, r, 1'b1, n);
        e.cyc = n; e.rd = r; e.data = 32'h0; e.rw = 1'b0; e.mis = 1'b1; e.dchk = 1'b1;
        wb_q.push_back(e);
    endtask

    // Aligned load/store: grant after w wait cycles; load data returns d cycles after grant
    task automatic mem_op(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [2:0] f3, input int w, input int d, input logic [31:0] rdat,
                          input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] edata,
                          input logic [4:0] r, input logic rw);
        int n;
        int cnt;
        wb_exp_t  e;
        bus_exp_t b;
        issue(32'h5555_5555, addr, wd, !wr, wr, f3, r, rw, n);
        b.addr = {addr[31:2], 2'b00}; b.we = wr; b.be = ebe; b.wdata = ewd;
        bus_q.push_back(b);
        e.cyc = wr ? n + w + 1 : n + w + 1 + d;
        e.rd = r; e.data = edata; e.rw = wr ? 1'b0 : rw; e.mis = 1'b0; e.dchk = !wr;
        wb_q.push_back(e);
        cnt = 0;
        for (int i = 0; i <= w; i++) begin
            if (i == w) dbus.dbus_gnt = 1'b1;
            if (dbus.dbus_req) cnt++;
            @(posedge clk); #1;
        end
        dbus.dbus_gnt = 1'b0;
        chk("req_cycles", 32'(cnt), 32'(w + 1));
        chk("req_drop", 32'(dbus.dbus_req), 32'd0);
        if (!wr) begin
            for (int i = 1; i < d; i++) begin
                chk("ready_in_resp", 32'(in_ready), 32'd0);
                @(posedge clk); #1;
            end
            dbus.dbus_rvalid = 1'b1;
            dbus.dbus_rdata  = rdat;
            @(posedge clk); #1;
            dbus.dbus_rvalid = 1'b0;
            dbus.dbus_rdata  = 32'h0BAD_F00D;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        bus_exp_t b;
        rst = 1'b1; in_valid = 1'b0; alu_result = 32'h0; mem_addr = 32'h0; mem_wdata = 32'h0;
        mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b0; rd = 5'd0; reg_write = 1'b0;
        dbus.dbus_gnt = 1'b0; dbus.dbus_rvalid = 1'b0; dbus.dbus_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_dbus_req", 32'(dbus.dbus_req), 32'd0);
        chk("rst_dbus_be", 32'(dbus.dbus_be), 32'd0);
        chk("rst_dbus_addr", dbus.dbus_addr, 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ALU pass-through, then three back-to-back
        alu_op(32'h9999_9999, 5'd5, 1'b1);
        alu_op(32'h1111_1111, 5'd1, 1'b1);
        alu_op(32'h2222_2222, 5'd2, 1'b0);
        alu_op(32'h3333_3333, 5'd3, 1'b1);

        // Stores: wr, addr, wdata, f3, w, d, rdata, be, steered wdata, data, rd, rw
        mem_op(1'b1, 32'h1000_0100, 32'hDEAD_BEEF, 3'b010, 2, 0, 32'h0, 4'b1111, 32'hDEAD_BEEF, 32'h0, 5'd4, 1'b1);
        mem_op(1'b1, 32'h1000_0103, 32'h0000_00AB, 3'b000, 0, 0, 32'h0, 4'b1000, 32'hABAB_ABAB, 32'h0, 5'd6, 1'b1);
        mem_op(1'b1, 32'h1000_0102, 32'h0000_1234, 3'b001, 1, 0, 32'h0, 4'b1100, 32'h1234_1234, 32'h0, 5'd7, 1'b1);
        mem_op(1'b1, 32'h1000_0101, 32'hFFFF_FF5A, 3'b000, 0, 0, 32'h0, 4'b0010, 32'h5A5A_5A5A, 32'h0, 5'd8, 1'b1);
        mem_op(1'b1, 32'h1000_0100, 32'hCAFE_8642, 3'b001, 0, 0, 32'h0, 4'b0011, 32'h8642_8642, 32'h0, 5'd9, 1'b1);
        mem_op(1'b1, 32'h1000_0104, 32'h0102_0304, 3'b011, 0, 0, 32'h0, 4'b1111, 32'h0102_0304, 32'h0, 5'd9, 1'b1);

        // Loads from rdata 8070_F0FF
        mem_op(1'b0, 32'h1000_0100, 32'h0, 3'b000, 0, 3, 32'h8070_F0FF, 4'b0001, 32'h0, 32'hFFFF_FFFF, 5'd10, 1'b1);
        mem_op(1'b0, 32'h1000_0101, 32'h0, 3'b100, 0, 1, 32'h8070_F0FF, 4'b0010, 32'h0, 32'h0000_00F0, 5'd11, 1'b1);
        mem_op(1'b0, 32'h1000_0102, 32'h0, 3'b001, 0, 2, 32'h8070_F0FF, 4'b1100, 32'h0, 32'hFFFF_8070, 5'd12, 1'b1);
        mem_op(1'b0, 32'h1000_0102, 32'h0, 3'b101, 0, 1, 32'h8070_F0FF, 4'b1100, 32'h0, 32'h0000_8070, 5'd13, 1'b1);
        mem_op(1'b0, 32'h1000_0100, 32'h0, 3'b010, 1, 1, 32'h8070_F0FF, 4'b1111, 32'h0, 32'h8070_F0FF, 5'd14, 1'b1);
        mem_op(1'b0, 32'h1000_0108, 32'h0, 3'b010, 0, 1, 32'h1357_9BDF, 4'b1111, 32'h0, 32'h1357_9BDF, 5'd15, 1'b0);

        // Stray rvalid and gnt while idle must produce nothing
        dbus.dbus_rvalid = 1'b1; dbus.dbus_gnt = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        dbus.dbus_rvalid = 1'b0; dbus.dbus_gnt = 1'b0;

        // Misaligned accesses
        misaligned_op(1'b0, 32'h1000_0102, 3'b010, 5'd16);
        misaligned_op(1'b0, 32'h1000_0101, 3'b001, 5'd17);
        misaligned_op(1'b1, 32'h1000_0103, 3'b101, 5'd18);
        alu_op(32'hA5A5_0001, 5'd19, 1'b1);

        // Reset while a store waits for grant
        issue(32'h0, 32'h0000_0200, 32'h1, 1'b0, 1'b1, 3'b010, 5'd20, 1'b1, n);
        b.addr = 32'h0000_0200; b.we = 1'b1; b.be = 4'b1111; b.wdata = 32'h1;
        bus_q.push_back(b);
        chk("req_before_rst", 32'(dbus.dbus_req), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_req_dbus_req", 32'(dbus.dbus_req), 32'd0);
        chk("rst_req_in_ready", 32'(in_ready), 32'd1);
        chk("rst_req_wb_valid", 32'(wb_valid), 32'd0);
        bus_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset while a load waits for its response
        issue(32'h0, 32'h0000_0300, 32'h0, 1'b1, 1'b0, 3'b010, 5'd21, 1'b1, n);
        b.addr = 32'h0000_0300; b.we = 1'b0; b.be = 4'b1111; b.wdata = 32'h0;
        bus_q.push_back(b);
        dbus.dbus_gnt = 1'b1;
        @(posedge clk); #1;
        dbus.dbus_gnt = 1'b0;
        chk("resp_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_resp_dbus_req", 32'(dbus.dbus_req), 32'd0);
        chk("rst_resp_in_ready", 32'(in_ready), 32'd1);
        chk("rst_resp_wb_valid", 32'(wb_valid), 32'd0);
        dbus.dbus_rvalid = 1'b1; dbus.dbus_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        dbus.dbus_rvalid = 1'b0;
        alu_op(32'h0BEE_F00D, 5'd22, 1'b1);

        repeat (3) begin @(posedge clk); #1; end
        chk("wb_queue_drained", 32'(wb_q.size()), 32'd0);
        chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
